// File: rtl/grey_10_pkg.sv
// Shared definitions for the decade ring code: code table, digit width, checker states.
// The grey_10 counter and every consumer of its ring code use this one table.
package grey_10_pkg;

   localparam int DIGIT_W = 4;
   localparam int CODE_W  = 5;

   localparam logic [DIGIT_W-1:0] DIGIT_BAD  = 4'hF;
   localparam logic [DIGIT_W-1:0] DIGIT_LAST = 4'd9;

   localparam logic [CODE_W-1:0] CODE_0 = 5'b10001;
   localparam logic [CODE_W-1:0] CODE_1 = 5'b00001;
   localparam logic [CODE_W-1:0] CODE_2 = 5'b00011;
   localparam logic [CODE_W-1:0] CODE_3 = 5'b00010;
   localparam logic [CODE_W-1:0] CODE_4 = 5'b00110;
   localparam logic [CODE_W-1:0] CODE_5 = 5'b00100;
   localparam logic [CODE_W-1:0] CODE_6 = 5'b01100;
   localparam logic [CODE_W-1:0] CODE_7 = 5'b01000;
   localparam logic [CODE_W-1:0] CODE_8 = 5'b11000;
   localparam logic [CODE_W-1:0] CODE_9 = 5'b10000;

   localparam logic [CODE_W-1:0] CODE_TABLE [10] = '{
      CODE_0, CODE_1, CODE_2, CODE_3, CODE_4,
      CODE_5, CODE_6, CODE_7, CODE_8, CODE_9
   };

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKING  = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   function automatic logic [DIGIT_W-1:0] digit_succ(input logic [DIGIT_W-1:0] digit);
      return (digit == DIGIT_LAST) ? '0 : digit + 4'd1;
   endfunction

endpackage

// File: rtl/grey_10_dec.sv
// Combinational ring-code decoder: reports whether a code is one of the ten legal
// codes and, if so, its binary digit (DIGIT_BAD otherwise).
module grey_10_dec
   import grey_10_pkg::*;
(
   input  logic [CODE_W-1:0]  code,
   output logic               legal,
   output logic [DIGIT_W-1:0] digit
);

   always_comb begin
      legal = 1'b1;
      digit = DIGIT_BAD;
      case (code)
         CODE_0:  digit = 4'd0;
         CODE_1:  digit = 4'd1;
         CODE_2:  digit = 4'd2;
         CODE_3:  digit = 4'd3;
         CODE_4:  digit = 4'd4;
         CODE_5:  digit = 4'd5;
         CODE_6:  digit = 4'd6;
         CODE_7:  digit = 4'd7;
         CODE_8:  digit = 4'd8;
         CODE_9:  digit = 4'd9;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/grey_10_check.sv
// Checker for the grey_10 decade ring code: decodes each sample, tracks the
// expected successor and declares lock after pLOCK_CNT consecutive advances.
//
//   state    | meaning
//   UNLOCKED | no reference digit held (after reset or an illegal code)
//   LOCKING  | reference held, counting consecutive advances toward pLOCK_CNT
//   LOCKED   | pLOCK_CNT advances seen; holds and advances keep lock
module grey_10_check
   import grey_10_pkg::*;
#(
   parameter int pLOCK_CNT = 4
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [CODE_W-1:0]  i_code,
   input  logic               i_valid,
   output logic [DIGIT_W-1:0] o_digit,
   output logic               o_valid,
   output logic               o_carry,
   output logic               o_err_code,
   output logic               o_err_seq,
   output logic               o_locked,
   output logic [7:0]         o_err_cnt
);

   localparam logic [3:0] LOCK_TGT = 4'(pLOCK_CNT);

   state_t             state;
   logic               ref_valid;
   logic [DIGIT_W-1:0] ref_digit;
   logic [3:0]         lock_cnt;

   logic               dec_legal;
   logic [DIGIT_W-1:0] dec_digit;
   logic               is_hold;
   logic               is_adv;
   logic               is_seq;
   logic               err_hit;

   grey_10_dec u_dec (
      .code  (i_code),
      .legal (dec_legal),
      .digit (dec_digit)
   );

   always_comb begin
      is_hold = ref_valid && (dec_digit == ref_digit);
      is_adv  = ref_valid && (dec_digit == digit_succ(ref_digit));
      is_seq  = dec_legal && ref_valid && !is_hold && !is_adv;
      err_hit = !dec_legal || is_seq;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= UNLOCKED;
         ref_valid  <= 1'b0;
         ref_digit  <= '0;
         lock_cnt   <= '0;
         o_digit    <= '0;
         o_valid    <= 1'b0;
         o_carry    <= 1'b0;
         o_err_code <= 1'b0;
         o_err_seq  <= 1'b0;
         o_locked   <= 1'b0;
         o_err_cnt  <= '0;
      end else begin
         o_valid    <= i_valid;
         o_carry    <= 1'b0;
         o_err_code <= 1'b0;
         o_err_seq  <= 1'b0;
         if (i_valid) begin
            if (!dec_legal) begin
               o_digit    <= DIGIT_BAD;
               o_err_code <= 1'b1;
               ref_valid  <= 1'b0;
               ref_digit  <= '0;
               lock_cnt   <= '0;
               state      <= UNLOCKED;
               o_locked   <= 1'b0;
            end else begin
               o_digit   <= dec_digit;
               ref_valid <= 1'b1;
               ref_digit <= dec_digit;
               if (!ref_valid) begin
                  lock_cnt <= '0;
                  state    <= LOCKING;
                  o_locked <= 1'b0;
               end else if (is_adv) begin
                  o_carry <= (ref_digit == DIGIT_LAST);
                  // once locked the count rests at the target, so it never exceeds it
                  if (state != LOCKED) begin
                     lock_cnt <= lock_cnt + 4'd1;
                     if (lock_cnt + 4'd1 == LOCK_TGT) begin
                        state    <= LOCKED;
                        o_locked <= 1'b1;
                     end else begin
                        state    <= LOCKING;
                     end
                  end
               end else if (is_seq) begin
                  o_err_seq <= 1'b1;
                  lock_cnt  <= '0;
                  state     <= LOCKING;
                  o_locked  <= 1'b0;
               end
            end
            if (err_hit && (o_err_cnt != 8'hFF))
               o_err_cnt <= o_err_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_grey_10_check.sv
// Directed bench for grey_10_check with pLOCK_CNT = 4: acquisition, carry,
// illegal and out-of-sequence codes, holds with gaps, counter saturation, reset.
module tb_grey_10_check;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [4:0] i_code;
   logic       i_valid;
   logic [3:0] o_digit;
   logic       o_valid;
   logic       o_carry;
   logic       o_err_code;
   logic       o_err_seq;
   logic       o_locked;
   logic [7:0] o_err_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   logic [4:0] ring [10];
   logic [4:0] bad  [22];

   grey_10_check #(.pLOCK_CNT(4)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_code     (i_code),
      .i_valid    (i_valid),
      .o_digit    (o_digit),
      .o_valid    (o_valid),
      .o_carry    (o_carry),
      .o_err_code (o_err_code),
      .o_err_seq  (o_err_seq),
      .o_locked   (o_locked),
      .o_err_cnt  (o_err_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] code, input logic valid);
      i_code  = code;
      i_valid = valid;
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [3:0] digit, input logic valid,
                          input logic carry, input logic ecode, input logic eseq,
                          input logic locked, input logic [7:0] ecnt);
      chk({tag, ".digit"},   8'(o_digit),    8'(digit));
      chk({tag, ".valid"},   8'(o_valid),    8'(valid));
      chk({tag, ".carry"},   8'(o_carry),    8'(carry));
      chk({tag, ".errcode"}, 8'(o_err_code), 8'(ecode));
      chk({tag, ".errseq"},  8'(o_err_seq),  8'(eseq));
      chk({tag, ".locked"},  8'(o_locked),   8'(locked));
      chk({tag, ".errcnt"},  o_err_cnt,      ecnt);
   endtask

   initial begin
      ring = '{5'b10001, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
               5'b00100, 5'b01100, 5'b01000, 5'b11000, 5'b10000};
      bad  = '{5'd0, 5'd5, 5'd7, 5'd9, 5'd10, 5'd11, 5'd13, 5'd14, 5'd15, 5'd18, 5'd19,
               5'd20, 5'd21, 5'd22, 5'd23, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31};

      // reset with a legal sample presented: sample must be discarded
      i_rst_n = 1'b0;
      drive(ring[3], 1'b1);
      drive(ring[4], 1'b1);
      chk_all("reset", 4'd0, 0, 0, 0, 0, 0, 8'd0);

      // acquisition: lock after the 5th sample, carry on the 11th (9 -> 0)
      i_rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         drive(ring[(k - 1) % 10], 1'b1);
         chk_all($sformatf("acq%0d", k), 4'((k - 1) % 10), 1, (k == 11), 0, 0, (k >= 5), 8'd0);
      end
      drive(5'b11111, 1'b0);
      chk_all("gap_after_acq", 4'd1, 0, 0, 0, 0, 1, 8'd0);

      // illegal code while locked drops to UNLOCKED, next legal has no seq check
      drive(5'b11111, 1'b1);
      chk_all("inj_bad", 4'hF, 1, 0, 1, 0, 0, 8'd1);
      drive(ring[9], 1'b1);
      chk_all("relock9", 4'd9, 1, 0, 0, 0, 0, 8'd1);
      drive(ring[0], 1'b1);
      chk_all("relock0", 4'd0, 1, 1, 0, 0, 0, 8'd1);
      drive(ring[1], 1'b1);
      chk_all("relock1", 4'd1, 1, 0, 0, 0, 0, 8'd1);
      drive(ring[2], 1'b1);
      chk_all("relock2", 4'd2, 1, 0, 0, 0, 0, 8'd1);
      drive(ring[3], 1'b1);
      chk_all("relock3", 4'd3, 1, 0, 0, 0, 1, 8'd1);

      // out-of-sequence jump 3 -> 6, then re-acquire on 7,8,9,0
      drive(ring[6], 1'b1);
      chk_all("seq6", 4'd6, 1, 0, 0, 1, 0, 8'd2);
      drive(ring[7], 1'b1);
      chk_all("seq7", 4'd7, 1, 0, 0, 0, 0, 8'd2);
      drive(ring[8], 1'b1);
      chk_all("seq8", 4'd8, 1, 0, 0, 0, 0, 8'd2);
      drive(ring[9], 1'b1);
      chk_all("seq9", 4'd9, 1, 0, 0, 0, 0, 8'd2);
      drive(ring[0], 1'b1);
      chk_all("seq0", 4'd0, 1, 1, 0, 0, 1, 8'd2);

      // advance to 4, then hold 4 three times with 2-cycle valid gaps
      for (int d = 1; d <= 4; d++) begin
         drive(ring[d], 1'b1);
         chk_all($sformatf("to4_%0d", d), 4'(d), 1, 0, 0, 0, 1, 8'd2);
      end
      for (int h = 0; h < 3; h++) begin
         drive(ring[4], 1'b1);
         chk_all($sformatf("hold%0d", h), 4'd4, 1, 0, 0, 0, 1, 8'd2);
         drive(5'b11111, 1'b0);
         chk_all($sformatf("holdgap%0da", h), 4'd4, 0, 0, 0, 0, 1, 8'd2);
         drive(ring[7], 1'b0);
         chk_all($sformatf("holdgap%0db", h), 4'd4, 0, 0, 0, 0, 1, 8'd2);
      end

      // 300 illegal samples: every illegal code decodes bad, counter saturates
      for (int i = 0; i < 300; i++) begin
         drive(bad[i % 22], 1'b1);
         if (i < 22)
            chk_all($sformatf("bad%0d", bad[i]), 4'hF, 1, 0, 1, 0, 0, 8'(i + 3));
         if (i == 251)
            chk("errcnt_254", o_err_cnt, 8'd254);
         if (i == 252)
            chk("errcnt_255", o_err_cnt, 8'd255);
      end
      chk_all("sat_end", 4'hF, 1, 0, 1, 0, 0, 8'd255);

      // reset wins over a valid sample; full re-acquisition needed afterwards
      i_rst_n = 1'b0;
      drive(ring[5], 1'b1);
      chk_all("reset2", 4'd0, 0, 0, 0, 0, 0, 8'd0);
      i_rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         drive(ring[k + 4], 1'b1);
         chk_all($sformatf("reacq%0d", k), 4'(k + 4), 1, 0, 0, 0, (k == 5), 8'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/grey_10_check.md
GREY_10_CHECK -- requirements
Module: grey_10_check

Interface
REQ-001 Parameter pLOCK_CNT, default 4, SHALL set the number of consecutive correct successor samples required to declare lock (legal range 1..15).
REQ-002 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  SHALL be the reset: synchronous and active-low.
REQ-004 i_code  input  5  SHALL carry the decade ring code produced by the grey_10 counter.
REQ-005 i_valid  input  1  SHALL qualify i_code; when high, i_code is sampled on that rising edge.
REQ-006 o_digit  output  4  SHALL be the registered binary digit 0..9 of the last sample, or 4'hF if illegal.
REQ-007 o_valid  output  1  SHALL pulse for one cycle per accepted sample.
REQ-008 o_carry  output  1  SHALL pulse with o_valid on a correct 9->0 transition.
REQ-009 o_err_code  output  1  SHALL pulse with o_valid when the sample is not one of the ten legal codes.
REQ-010 o_err_seq  output  1  SHALL pulse with o_valid when a legal sample is neither the held code nor its successor.
REQ-011 o_locked  output  1  SHALL be high while the checker FSM is in LOCKED.
REQ-012 o_err_cnt  output  8  SHALL be the saturating count of error pulses since reset.

Function
REQ-013 Decode SHALL be exact: 10001=0, 00001=1, 00011=2, 00010=3, 00110=4, 00100=5, 01100=6, 01000=7, 11000=8, 10000=9; all other 22 codes illegal.
REQ-014 Latency SHALL be one cycle: sample at edge N -> o_valid, o_digit, and pulses visible after edge N, then cleared after edge N+1 unless a new sample is accepted.
REQ-015 With i_valid low: o_valid, o_carry, o_err_code, o_err_seq SHALL be 0; o_digit, state, reference, lock count hold.
REQ-016 A reference digit SHALL be stored on every legal sample; an illegal sample SHALL clear the reference.
REQ-017 Legal sample with reference present: same digit = hold (no error, no carry, lock count unchanged); (ref+1) mod 10 = advance; anything else = sequence error.
REQ-018 FSM states SHALL be UNLOCKED, LOCKING, LOCKED.
REQ-019 UNLOCKED: legal sample -> LOCKING, lock count 0; illegal sample -> stay, o_err_code pulses.
REQ-020 LOCKING: advance -> lock count +1, and when count reaches pLOCK_CNT -> LOCKED; sequence error -> stay LOCKING, count 0, reference = new digit; illegal -> UNLOCKED.
REQ-021 LOCKED: advance or hold -> stay; sequence error -> LOCKING, count 0, reference = new digit; illegal -> UNLOCKED.
REQ-022 o_carry SHALL pulse on any advance from 9 to 0 regardless of state; never on hold or error.
REQ-023 o_err_code and o_err_seq SHALL be mutually exclusive; no sequence check when no reference (first sample after reset or after illegal).
REQ-024 o_err_cnt SHALL increment by 1 per sample with either error pulse and SHALL stick at 255.
REQ-025 Lock count SHALL be 4 bits and never exceed pLOCK_CNT.

Reset
REQ-026 With i_rst_n low at a rising edge: o_digit=0, o_valid=0, o_carry=0, o_err_code=0, o_err_seq=0, o_locked=0, o_err_cnt=0, state UNLOCKED, reference cleared, lock count 0.
REQ-027 Reset SHALL take precedence over i_valid on the same edge; a sample presented during reset is discarded.
REQ-028 Reset mid-lock SHALL require full re-acquisition (first legal sample + pLOCK_CNT advances).

Structure
REQ-029 Shared package grey_10_pkg SHALL hold the ten code constants, the FSM state encoding, and the digit width.
REQ-030 Sub-module grey_10_dec SHALL be a combinational code-to-{legal, digit} decoder, reused by other consumers of the ring code.
REQ-031 The grey_10 counter SHALL take its code constants from grey_10_pkg so that both ends share one table.

Verification
REQ-032 Reset, then grey_10 driving i_code with i_valid=1, pLOCK_CNT=4 -> o_locked rises after edge 5 (first sample + 4 advances); o_carry pulses once every 10 samples at digit 0.
REQ-033 LOCKED, inject 5'b11111 once -> o_digit=F, o_err_code=1, o_locked=0, o_err_cnt=1; next legal code -> LOCKING, no o_err_seq.
REQ-034 LOCKED at digit 3, inject code for 6 -> o_err_seq=1, o_digit=6, state LOCKING; 7,8,9,0 follow -> o_locked=1 and o_carry on the 0.
REQ-035 Hold digit 4 for 3 samples with i_valid gaps of 2 cycles -> no errors, o_valid only on sampled cycles, o_locked unchanged.
REQ-036 300 illegal samples -> o_err_cnt saturates at 255; drive i_rst_n=0 with i_valid=1 -> all outputs 0 on next edge.
